// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared requester IDs, size encodings and bus widths
package mem_bus_arbiter_pkg;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STRB_W     = 4;
   localparam int BUS_SIZE_W = 2;

   typedef enum logic {
      ID_INST = 1'b0,
      ID_DATA = 1'b1
   } req_id_e;

   localparam logic [BUS_SIZE_W-1:0] SIZE_B = 2'd0;
   localparam logic [BUS_SIZE_W-1:0] SIZE_H = 2'd1;
   localparam logic [BUS_SIZE_W-1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_id_fifo.sv
// rtl/mem_bus_arbiter_id_fifo.sv - 1-bit in-order owner FIFO for outstanding requests
module mem_bus_arbiter_id_fifo #(
   parameter int DEPTH = 4
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_push,
   input  logic i_din,
   input  logic i_pop,
   output logic o_dout,
   output logic o_full,
   output logic o_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic          r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   // DEPTH is a power of two, so the pointers wrap by plain overflow
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_din;
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one sram-like port between inst fetch and data requesters
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int OUTST_DEPTH = 4,
   parameter int STARVE_LIM  = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_inst_req,
   input  logic [ADDR_W-1:0]     i_inst_addr,
   output logic                  o_inst_addr_ok,
   output logic                  o_inst_data_ok,
   output logic [DATA_W-1:0]     o_inst_rdata,
   input  logic                  i_data_req,
   input  logic                  i_data_wr,
   input  logic [BUS_SIZE_W-1:0] i_data_size,
   input  logic [STRB_W-1:0]     i_data_wstrb,
   input  logic [ADDR_W-1:0]     i_data_addr,
   input  logic [DATA_W-1:0]     i_data_wdata,
   output logic                  o_data_addr_ok,
   output logic                  o_data_data_ok,
   output logic [DATA_W-1:0]     o_data_rdata,
   output logic                  o_bus_req,
   output logic                  o_bus_wr,
   output logic [BUS_SIZE_W-1:0] o_bus_size,
   output logic [STRB_W-1:0]     o_bus_wstrb,
   output logic [ADDR_W-1:0]     o_bus_addr,
   output logic [DATA_W-1:0]     o_bus_wdata,
   input  logic                  i_bus_addr_ok,
   input  logic                  i_bus_data_ok,
   input  logic [DATA_W-1:0]     i_bus_rdata,
   output logic                  o_resp_err
);

   localparam int SW = $clog2(STARVE_LIM + 1);

   logic          r_lock_vld;
   req_id_e       r_lock_id;
   logic [SW-1:0] r_starve_cnt;
   logic          r_resp_err;

   logic    w_grant_vld;
   req_id_e w_grant_id;
   logic    w_full;
   logic    w_empty;
   logic    w_head;
   logic    w_bus_req;
   logic    w_accept;
   logic    w_pop;

   // A stalled address phase locks the grant so its fields cannot change under the slave
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_id  = ID_INST;
      if (r_lock_vld) begin
         w_grant_vld = 1'b1;
         w_grant_id  = r_lock_id;
      end else if (i_data_req && !(i_inst_req && r_starve_cnt == SW'(STARVE_LIM))) begin
         w_grant_vld = 1'b1;
         w_grant_id  = ID_DATA;
      end else if (i_inst_req) begin
         w_grant_vld = 1'b1;
         w_grant_id  = ID_INST;
      end
   end

   assign w_bus_req = w_grant_vld && !w_full;
   assign w_accept  = w_bus_req && i_bus_addr_ok;
   assign w_pop     = i_bus_data_ok && !w_empty;

   always_comb begin
      o_bus_wr    = 1'b0;
      o_bus_size  = SIZE_W;
      o_bus_wstrb = '0;
      o_bus_addr  = i_inst_addr;
      o_bus_wdata = '0;
      if (w_grant_id == ID_DATA) begin
         o_bus_wr    = i_data_wr;
         o_bus_size  = i_data_size;
         o_bus_wstrb = i_data_wstrb;
         o_bus_addr  = i_data_addr;
         o_bus_wdata = i_data_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_lock_vld <= 1'b0;
         r_lock_id  <= ID_INST;
      end else if (w_accept) begin
         r_lock_vld <= 1'b0;
      end else if (w_bus_req) begin
         r_lock_vld <= 1'b1;
         r_lock_id  <= w_grant_id;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_starve_cnt <= '0;
      end else if (!i_inst_req) begin
         r_starve_cnt <= '0;
      end else if (w_accept) begin
         if (w_grant_id == ID_INST)
            r_starve_cnt <= '0;
         else if (r_starve_cnt != SW'(STARVE_LIM))
            r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn)
         r_resp_err <= 1'b0;
      else if (i_bus_data_ok && w_empty)
         r_resp_err <= 1'b1;
   end

   mem_bus_arbiter_id_fifo #(
      .DEPTH (OUTST_DEPTH)
   ) u_id_fifo (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_push  (w_accept),
      .i_din   (w_grant_id),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign o_bus_req      = w_bus_req;
   assign o_inst_addr_ok = w_accept && (w_grant_id == ID_INST);
   assign o_data_addr_ok = w_accept && (w_grant_id == ID_DATA);
   assign o_inst_data_ok = w_pop && (w_head == ID_INST);
   assign o_data_data_ok = w_pop && (w_head == ID_DATA);
   assign o_inst_rdata   = i_bus_rdata;
   assign o_data_rdata   = i_bus_rdata;
   assign o_resp_err     = r_resp_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        bus_req, bus_wr;
   logic [1:0]  bus_size;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_addr_ok, bus_data_ok;
   logic [31:0] bus_rdata;
   logic        resp_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .OUTST_DEPTH (4),
      .STARVE_LIM  (4)
   ) dut (
      .i_clk          (clk),
      .i_rstn         (rstn),
      .i_inst_req     (inst_req),
      .i_inst_addr    (inst_addr),
      .o_inst_addr_ok (inst_addr_ok),
      .o_inst_data_ok (inst_data_ok),
      .o_inst_rdata   (inst_rdata),
      .i_data_req     (data_req),
      .i_data_wr      (data_wr),
      .i_data_size    (data_size),
      .i_data_wstrb   (data_wstrb),
      .i_data_addr    (data_addr),
      .i_data_wdata   (data_wdata),
      .o_data_addr_ok (data_addr_ok),
      .o_data_data_ok (data_data_ok),
      .o_data_rdata   (data_rdata),
      .o_bus_req      (bus_req),
      .o_bus_wr       (bus_wr),
      .o_bus_size     (bus_size),
      .o_bus_wstrb    (bus_wstrb),
      .o_bus_addr     (bus_addr),
      .o_bus_wdata    (bus_wdata),
      .i_bus_addr_ok  (bus_addr_ok),
      .i_bus_data_ok  (bus_data_ok),
      .i_bus_rdata    (bus_rdata),
      .o_resp_err     (resp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      rstn = 1'b0;  inst_req = 1'b0; inst_addr = '0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = '0;
      data_addr = '0; data_wdata = '0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
      tick(); tick();
      rstn = 1'b1;
      sample();
      check("rst_bus_req",  32'(bus_req), 0);
      check("rst_resp_err", 32'(resp_err), 0);
      check("rst_i_dok",    32'(inst_data_ok), 0);
      check("rst_d_dok",    32'(data_data_ok), 0);
      tick();

      // single inst read, response two cycles after accept
      inst_req = 1'b1; inst_addr = 32'h1C000000; bus_addr_ok = 1'b1;
      sample();
      check("t1_addr_ok", 32'(inst_addr_ok), 1);
      check("t1_addr",    bus_addr, 32'h1C000000);
      check("t1_wr",      32'(bus_wr), 0);
      check("t1_size",    32'(bus_size), 2);
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b0;
      sample();
      check("t1_c1_dok",  32'(inst_data_ok), 0);
      tick();
      bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
      sample();
      check("t1_i_dok",   32'(inst_data_ok), 1);
      check("t1_rdata",   inst_rdata, 32'hDEADBEEF);
      check("t1_d_dok",   32'(data_data_ok), 0);
      tick();
      bus_data_ok = 1'b0;

      // simultaneous requests: data first, then inst; responses routed D then I
      inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
      data_wstrb = 4'b0001; data_addr = 32'h80; data_wdata = 32'h000000A5;
      bus_addr_ok = 1'b1;
      sample();
      check("t2_d_aok",   32'(data_addr_ok), 1);
      check("t2_i_aok0",  32'(inst_addr_ok), 0);
      check("t2_wstrb",   32'(bus_wstrb), 1);
      check("t2_addr",    bus_addr, 32'h80);
      check("t2_size",    32'(bus_size), 0);
      check("t2_wdata",   bus_wdata, 32'hA5);
      tick();
      data_req = 1'b0;
      sample();
      check("t2_i_aok",   32'(inst_addr_ok), 1);
      check("t2_i_addr",  bus_addr, 32'h1C000000);
      check("t2_i_wstrb", 32'(bus_wstrb), 0);
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h11111111;
      sample();
      check("t2_r1_d",    32'(data_data_ok), 1);
      check("t2_r1_i",    32'(inst_data_ok), 0);
      tick();
      bus_rdata = 32'h22222222;
      sample();
      check("t2_r2_i",    32'(inst_data_ok), 1);
      check("t2_r2_d",    32'(data_data_ok), 0);
      check("t2_r2_data", inst_rdata, 32'h22222222);
      tick();
      bus_data_ok = 1'b0;

      // data held off for 3 cycles; inst rises meanwhile
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
      data_addr = 32'h200; data_wdata = 32'h12345678;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) begin inst_req = 1'b1; inst_addr = 32'h1C000040; end
         if (c == 3) bus_addr_ok = 1'b1;
         sample();
         check("t3_addr",  bus_addr, 32'h200);
         check("t3_wr",    32'(bus_wr), 1);
         check("t3_i_aok", 32'(inst_addr_ok), 0);
         check("t3_d_aok", 32'(data_addr_ok), (c == 3) ? 1 : 0);
         tick();
      end
      data_req = 1'b0;
      sample();
      check("t3_i_aok2",  32'(inst_addr_ok), 1);
      check("t3_i_addr",  bus_addr, 32'h1C000040);
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
      sample();
      check("t3_r1_d",    32'(data_data_ok), 1);
      tick();
      sample();
      check("t3_r2_i",    32'(inst_data_ok), 1);
      tick();
      bus_data_ok = 1'b0;

      // a stalled inst grant is not stolen by a later data request
      inst_req = 1'b1; inst_addr = 32'h1C000080;
      sample();
      check("t3b_req",    32'(bus_req), 1);
      tick();
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h400;
      sample();
      check("t3b_lock",   bus_addr, 32'h1C000080);
      check("t3b_d_aok",  32'(data_addr_ok), 0);
      tick();
      bus_addr_ok = 1'b1;
      sample();
      check("t3b_i_aok",  32'(inst_addr_ok), 1);
      tick();
      inst_req = 1'b0;
      sample();
      check("t3b_d_aok2", 32'(data_addr_ok), 1);
      tick();
      data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
      sample();
      check("t3b_r1_i",   32'(inst_data_ok), 1);
      tick();
      sample();
      check("t3b_r2_d",   32'(data_data_ok), 1);
      tick();
      bus_data_ok = 1'b0;

      // fill four outstanding, fifth blocked until a response frees a slot
      data_req = 1'b1; data_addr = 32'h300; bus_addr_ok = 1'b1;
      for (int c = 0; c < 4; c++) begin
         sample();
         check("t4_fill_aok", 32'(data_addr_ok), 1);
         tick();
      end
      sample();
      check("t4_full_req", 32'(bus_req), 0);
      check("t4_full_aok", 32'(data_addr_ok), 0);
      tick();
      bus_data_ok = 1'b1;
      sample();
      check("t4_pop_dok",  32'(data_data_ok), 1);
      check("t4_nobypass", 32'(bus_req), 0);
      tick();
      bus_data_ok = 1'b0;
      sample();
      check("t4_5th_aok",  32'(data_addr_ok), 1);
      tick();
      data_req = 1'b0; bus_data_ok = 1'b1;
      for (int c = 0; c < 4; c++) begin
         sample();
         check("t4_drain",   32'(data_data_ok), 1);
         tick();
      end
      bus_data_ok = 1'b0;

      // both held: four data accepts, then one inst, repeated
      inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h1C000100; data_addr = 32'h500;
      for (int k = 0; k < 10; k++) begin
         bus_data_ok = (k >= 1);
         sample();
         check("t5_d_aok", 32'(data_addr_ok), (k % 5 != 4) ? 1 : 0);
         check("t5_i_aok", 32'(inst_addr_ok), (k % 5 == 4) ? 1 : 0);
         if (k >= 1)
            check("t5_route", 32'(inst_data_ok), ((k - 1) % 5 == 4) ? 1 : 0);
         tick();
      end
      inst_req = 1'b0; data_req = 1'b0;
      sample();
      check("t5_last_i", 32'(inst_data_ok), 1);
      tick();

      // response with empty FIFO raises sticky resp_err
      sample();
      check("t6_empty_i", 32'(inst_data_ok), 0);
      check("t6_empty_d", 32'(data_data_ok), 0);
      tick();
      bus_data_ok = 1'b0;
      sample();
      check("t6_err",     32'(resp_err), 1);
      tick(); tick();
      sample();
      check("t6_sticky",  32'(resp_err), 1);
      tick();
      rstn = 1'b0;
      tick();
      sample();
      check("t6_rst_err", 32'(resp_err), 0);
      tick();
      rstn = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
